sp_ram_arbiter: RTL and testbench
=================================

SP_RAM_ARBITER -- requirements
Module: sp_ram_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 15: byte-address width on both master ports and the RAM port.
REQ-002 Parameter DATA_WIDTH, default 32: data width; byte-enable width is DATA_WIDTH/8.
REQ-003 clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 rst_i  in  1  reset, synchronous, active-high.
REQ-005 mN_req_i  in  1  master N request, for N = 0,1 (m0 = instruction side, m1 = data side).
REQ-006 mN_gnt_o  out  1  master N request accepted this cycle.
REQ-007 mN_addr_i  in  ADDR_WIDTH  master N byte address.
REQ-008 mN_we_i  in  1  master N write (1) or read (0).
REQ-009 mN_be_i  in  DATA_WIDTH/8  master N byte enables.
REQ-010 mN_wdata_i  in  DATA_WIDTH  master N write data.
REQ-011 mN_rvalid_o  out  1  master N response valid, for reads and writes.
REQ-012 mN_rdata_o  out  DATA_WIDTH  master N read data, meaningful only while mN_rvalid_o=1.
REQ-013 ram_en_o  out  1  RAM access enable.
REQ-014 ram_addr_o  out  ADDR_WIDTH  RAM address, from the granted master.
REQ-015 ram_we_o  out  1  RAM write enable, from the granted master.
REQ-016 ram_be_o  out  DATA_WIDTH/8  RAM byte enables, from the granted master.
REQ-017 ram_wdata_o  out  DATA_WIDTH  RAM write data, from the granted master.
REQ-018 ram_rdata_i  in  DATA_WIDTH  RAM read data, valid one cycle after ram_en_o.

Function
REQ-019 Grant decision shall be combinational in the request cycle; at most one mN_gnt_o is high per cycle.
REQ-020 Only one master requesting: that master is granted.
REQ-021 Both masters requesting: grant the master selected by priority register prio_q (0 = m0, 1 = m1).
REQ-022 prio_q shall update only on a contended cycle (both requesting): it becomes the index of the loser, so both masters alternate under continuous contention.
REQ-023 Uncontended grants shall leave prio_q unchanged.
REQ-024 ram_en_o = m0_gnt_o | m1_gnt_o; RAM address, we, be and wdata mux from the granted master; with no grant ram_we_o=0 and other RAM outputs are don't-care.
REQ-025 Registered owner state: valid_q is set on any grant, and owner_q is set to the granted index.
REQ-026 mN_rvalid_o = valid_q & (owner_q==N): exactly one cycle after the grant; one response per grant, writes included.
REQ-027 mN_rdata_o = ram_rdata_i for both masters (no register); qualified by mN_rvalid_o only.
REQ-028 Back-to-back grants in consecutive cycles shall be supported at full throughput (one access per cycle, no bubble).
REQ-029 A master shall hold req, addr, we, be and wdata stable until granted; a request withdrawn before grant is never issued to RAM.
REQ-030 Grant and response in the same cycle (new grant while valid_q=1) shall both be handled; the response belongs to the previous owner_q.

Reset
REQ-031 While rst_i=1 at a clock edge: prio_q<=0, valid_q<=0, owner_q<=0.
REQ-032 While rst_i=1, both mN_gnt_o and ram_en_o shall be forced to 0 regardless of requests.
REQ-033 Reset asserted one cycle after a grant suppresses that grant's rvalid; the response is discarded, and RAM contents written before reset are not rolled back.

Verification
REQ-034 Single read: m0 reads addr 0x0010 holding 0xDEADBEEF -> m0_gnt_o=1 in cycle T, m0_rvalid_o=1 and m0_rdata_o=0xDEADBEEF in T+1, m1_rvalid_o=0.
REQ-035 Contention from reset: both request in cycle T -> m0 granted at T, m1 granted at T+1 (m0 still requesting, prio_q=1), m0 granted at T+2.
REQ-036 Write then read: m1 writes 0x12345678 with be=4'b0011 to 0x0020 (old 0xFFFFFFFF) -> m1_rvalid_o=1 next cycle; a subsequent m0 read of 0x0020 returns 0xFFFF5678.
REQ-037 Streaming: m1 requests continuously for 8 cycles alone -> 8 grants and 8 rvalids, each one cycle after its grant, no gaps; prio_q is unchanged.
REQ-038 Reset mid-operation: grant m0 at T, rst_i=1 at T+1 -> m0_rvalid_o=0 at T+1, no grants during reset, prio_q=0 afterwards.
REQ-039 Random traffic: every grant yields exactly one rvalid to the same master one cycle later, and gnt signals are never high simultaneously.

Source files
------------

// File: rtl/sp_ram_arbiter.sv
// sp_ram_arbiter: two-master arbiter in front of a single-port synchronous RAM.
//
// Purpose:
//   m0 (instruction side) and m1 (data side) share one RAM port. The grant is
//   decided combinationally in the request cycle. When both masters request,
//   a one-bit priority register picks the winner and then flips to the loser,
//   so the two masters alternate under continuous contention. Every grant
//   gives exactly one response one cycle later, and that response goes to the
//   master that was granted.
//
// Ports:
//   clk, rst_i                    clock; synchronous active-high reset
//   mN_req_i / mN_gnt_o           master N request / accepted this cycle
//   mN_addr_i, mN_we_i,           master N byte address, write flag,
//   mN_be_i, mN_wdata_i           byte enables, write data
//   mN_rvalid_o, mN_rdata_o       master N response valid / read data
//   ram_en_o, ram_addr_o,         RAM enable, address,
//   ram_we_o, ram_be_o,           write enable, byte enables,
//   ram_wdata_o                   write data (all from the granted master)
//   ram_rdata_i                   RAM read data, valid one cycle after ram_en_o
module sp_ram_arbiter #(
    parameter int unsigned ADDR_WIDTH = 15,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst_i,

    input  logic                    m0_req_i,
    output logic                    m0_gnt_o,
    input  logic [ADDR_WIDTH-1:0]   m0_addr_i,
    input  logic                    m0_we_i,
    input  logic [DATA_WIDTH/8-1:0] m0_be_i,
    input  logic [DATA_WIDTH-1:0]   m0_wdata_i,
    output logic                    m0_rvalid_o,
    output logic [DATA_WIDTH-1:0]   m0_rdata_o,

    input  logic                    m1_req_i,
    output logic                    m1_gnt_o,
    input  logic [ADDR_WIDTH-1:0]   m1_addr_i,
    input  logic                    m1_we_i,
    input  logic [DATA_WIDTH/8-1:0] m1_be_i,
    input  logic [DATA_WIDTH-1:0]   m1_wdata_i,
    output logic                    m1_rvalid_o,
    output logic [DATA_WIDTH-1:0]   m1_rdata_o,

    output logic                    ram_en_o,
    output logic [ADDR_WIDTH-1:0]   ram_addr_o,
    output logic                    ram_we_o,
    output logic [DATA_WIDTH/8-1:0] ram_be_o,
    output logic [DATA_WIDTH-1:0]   ram_wdata_o,
    input  logic [DATA_WIDTH-1:0]   ram_rdata_i
);

    logic prio_q, prio_d;    // index of the master that wins the next contended cycle
    logic valid_q, valid_d;  // a response is due this cycle
    logic owner_q, owner_d;  // master that the due response belongs to
    logic gnt0, gnt1;
    logic contended;

    // Grant and next-state logic. Reset blocks all grants combinationally.
    always_comb begin
        contended = m0_req_i & m1_req_i;
        gnt0      = ~rst_i & m0_req_i & (~m1_req_i | ~prio_q);
        gnt1      = ~rst_i & m1_req_i & (~m0_req_i |  prio_q);

        valid_d = gnt0 | gnt1;

        owner_d = owner_q;
        if (gnt1) begin
            owner_d = 1'b1;
        end else if (gnt0) begin
            owner_d = 1'b0;
        end

        // On contention the loser gets priority next time: m0 winning means m1 is next.
        prio_d = prio_q;
        if (contended && !rst_i) begin
            prio_d = gnt0;
        end
    end

    // RAM request mux from the granted master.
    always_comb begin
        m0_gnt_o = gnt0;
        m1_gnt_o = gnt1;
        ram_en_o = gnt0 | gnt1;
        if (gnt1) begin
            ram_addr_o  = m1_addr_i;
            ram_we_o    = m1_we_i;
            ram_be_o    = m1_be_i;
            ram_wdata_o = m1_wdata_i;
        end else begin
            ram_addr_o  = m0_addr_i;
            ram_we_o    = m0_we_i & gnt0;
            ram_be_o    = m0_be_i;
            ram_wdata_o = m0_wdata_i;
        end
    end

    // Responses: rdata is passed straight through; rvalid selects the owner.
    // A reset in the response cycle discards that response.
    always_comb begin
        m0_rvalid_o = valid_q & ~owner_q & ~rst_i;
        m1_rvalid_o = valid_q &  owner_q & ~rst_i;
        m0_rdata_o  = ram_rdata_i;
        m1_rdata_o  = ram_rdata_i;
    end

    always_ff @(posedge clk) begin
        if (rst_i) begin
            prio_q  <= 1'b0;
            valid_q <= 1'b0;
            owner_q <= 1'b0;
        end else begin
            prio_q  <= prio_d;
            valid_q <= valid_d;
            owner_q <= owner_d;
        end
    end

endmodule

// File: tb/tb_sp_ram_arbiter.sv
// tb_sp_ram_arbiter: directed and random traffic against sp_ram_arbiter with a
// behavioural RAM, a reference model checked every cycle, and literal checks
// for the documented scenarios.
module tb_sp_ram_arbiter;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        m0_req_i, m1_req_i;
    logic        m0_gnt_o, m1_gnt_o;
    logic [14:0] m0_addr_i, m1_addr_i;
    logic        m0_we_i, m1_we_i;
    logic [3:0]  m0_be_i, m1_be_i;
    logic [31:0] m0_wdata_i, m1_wdata_i;
    logic        m0_rvalid_o, m1_rvalid_o;
    logic [31:0] m0_rdata_o, m1_rdata_o;
    logic        ram_en_o, ram_we_o;
    logic [14:0] ram_addr_o;
    logic [3:0]  ram_be_o;
    logic [31:0] ram_wdata_o;
    logic [31:0] ram_rdata_i;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sp_ram_arbiter #(.ADDR_WIDTH(15), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst_i(rst_i),
        .m0_req_i(m0_req_i), .m0_gnt_o(m0_gnt_o), .m0_addr_i(m0_addr_i),
        .m0_we_i(m0_we_i), .m0_be_i(m0_be_i), .m0_wdata_i(m0_wdata_i),
        .m0_rvalid_o(m0_rvalid_o), .m0_rdata_o(m0_rdata_o),
        .m1_req_i(m1_req_i), .m1_gnt_o(m1_gnt_o), .m1_addr_i(m1_addr_i),
        .m1_we_i(m1_we_i), .m1_be_i(m1_be_i), .m1_wdata_i(m1_wdata_i),
        .m1_rvalid_o(m1_rvalid_o), .m1_rdata_o(m1_rdata_o),
        .ram_en_o(ram_en_o), .ram_addr_o(ram_addr_o), .ram_we_o(ram_we_o),
        .ram_be_o(ram_be_o), .ram_wdata_o(ram_wdata_o), .ram_rdata_i(ram_rdata_i)
    );

    function automatic logic [31:0] init_word(int i);
        if (i == 4) return 32'hDEADBEEF;   // byte address 0x0010
        if (i == 8) return 32'hFFFFFFFF;   // byte address 0x0020
        return (32'(i) * 32'h01010101) ^ 32'hA5A5A5A5;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural single-port RAM: read-before-write, one-cycle read latency.
    logic [31:0] ram_mem [64];
    initial begin
        for (int i = 0; i < 64; i++) ram_mem[i] = init_word(i);
        ram_rdata_i = '0;
        forever begin
            @(posedge clk);
            if (ram_en_o) begin
                ram_rdata_i = ram_mem[ram_addr_o[7:2]];
                if (ram_we_o) begin
                    for (int b = 0; b < 4; b++) begin
                        if (ram_be_o[b]) ram_mem[ram_addr_o[7:2]][b*8 +: 8] = ram_wdata_o[b*8 +: 8];
                    end
                end
            end
        end
    end

    // Reference model: who should be granted, and which response is due.
    initial begin
        logic [31:0] ref_mem [64];
        int          m_next;       // master that wins the next contended cycle
        bit          pend_valid;
        int          pend_owner;
        bit          pend_read;
        logic [31:0] pend_data;
        int          win;
        logic [14:0] w_addr;
        logic        w_we;
        logic [3:0]  w_be;
        logic [31:0] w_wdata;
        for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
        m_next = 0; pend_valid = 0; pend_owner = 0; pend_read = 0; pend_data = '0;
        forever begin
            @(negedge clk);
            win = -1;
            if (rst_i !== 1'b1) begin
                if (m0_req_i && m1_req_i) win = m_next;
                else if (m0_req_i)        win = 0;
                else if (m1_req_i)        win = 1;
            end
            check("gnt0", 32'(m0_gnt_o), 32'(win == 0));
            check("gnt1", 32'(m1_gnt_o), 32'(win == 1));
            check("ram_en", 32'(ram_en_o), 32'(win >= 0));
            if (win >= 0) begin
                w_addr  = (win == 0) ? m0_addr_i  : m1_addr_i;
                w_we    = (win == 0) ? m0_we_i    : m1_we_i;
                w_be    = (win == 0) ? m0_be_i    : m1_be_i;
                w_wdata = (win == 0) ? m0_wdata_i : m1_wdata_i;
                check("ram_addr", 32'(ram_addr_o), 32'(w_addr));
                check("ram_we", 32'(ram_we_o), 32'(w_we));
                if (w_we) begin
                    check("ram_be", 32'(ram_be_o), 32'(w_be));
                    check("ram_wdata", ram_wdata_o, w_wdata);
                end
            end else begin
                check("ram_we_idle", 32'(ram_we_o), 32'd0);
            end
            check("rvalid0", 32'(m0_rvalid_o), 32'(pend_valid && rst_i !== 1'b1 && pend_owner == 0));
            check("rvalid1", 32'(m1_rvalid_o), 32'(pend_valid && rst_i !== 1'b1 && pend_owner == 1));
            if (pend_valid && pend_read && rst_i !== 1'b1) begin
                if (pend_owner == 0) check("rdata0", m0_rdata_o, pend_data);
                else                 check("rdata1", m1_rdata_o, pend_data);
            end
            // advance model to the next cycle
            if (rst_i === 1'b1) begin
                m_next = 0;
                pend_valid = 0;
            end else begin
                if (m0_req_i && m1_req_i) m_next = 1 - win;
                pend_valid = (win >= 0);
                if (win >= 0) begin
                    pend_owner = win;
                    pend_read  = !w_we;
                    pend_data  = ref_mem[w_addr[7:2]];
                    if (w_we) begin
                        for (int b = 0; b < 4; b++) begin
                            if (w_be[b]) ref_mem[w_addr[7:2]][b*8 +: 8] = w_wdata[b*8 +: 8];
                        end
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic m0_set(input logic req, input logic [14:0] a, input logic we,
                          input logic [3:0] be, input logic [31:0] wd);
        m0_req_i = req; m0_addr_i = a; m0_we_i = we; m0_be_i = be; m0_wdata_i = wd;
    endtask

    task automatic m1_set(input logic req, input logic [14:0] a, input logic we,
                          input logic [3:0] be, input logic [31:0] wd);
        m1_req_i = req; m1_addr_i = a; m1_we_i = we; m1_be_i = be; m1_wdata_i = wd;
    endtask

    initial begin
        bit          busy0, busy1;
        logic [5:0]  idx;
        rst_i = 1'b1;
        m0_set(0, '0, 0, 4'hF, '0);
        m1_set(0, '0, 0, 4'hF, '0);
        step(); step();
        @(negedge clk);
        check("reset_gnt0", 32'(m0_gnt_o), 32'd0);
        check("reset_rvalid0", 32'(m0_rvalid_o), 32'd0);
        step();
        rst_i = 1'b0;

        // Single read of 0x0010
        m0_set(1, 15'h0010, 0, 4'hF, '0);
        @(negedge clk); check("rd_gnt0", 32'(m0_gnt_o), 32'd1);
        step(); m0_set(0, '0, 0, 4'hF, '0);
        @(negedge clk);
        check("rd_rvalid0", 32'(m0_rvalid_o), 32'd1);
        check("rd_rdata0", m0_rdata_o, 32'hDEADBEEF);
        check("rd_rvalid1", 32'(m1_rvalid_o), 32'd0);

        // Contention from reset priority: m0, m1, m0
        step(); m0_set(1, 15'h0014, 0, 4'hF, '0); m1_set(1, 15'h0018, 0, 4'hF, '0);
        @(negedge clk); check("cont_t0_gnt0", 32'(m0_gnt_o), 32'd1);
        step();
        @(negedge clk); check("cont_t1_gnt1", 32'(m1_gnt_o), 32'd1);
        step();
        @(negedge clk); check("cont_t2_gnt0", 32'(m0_gnt_o), 32'd1);
        step(); m0_set(0, '0, 0, 4'hF, '0); m1_set(0, '0, 0, 4'hF, '0);

        // Partial write then read back
        m1_set(1, 15'h0020, 1, 4'b0011, 32'h12345678);
        @(negedge clk); check("wr_gnt1", 32'(m1_gnt_o), 32'd1);
        step(); m1_set(0, '0, 0, 4'hF, '0);
        @(negedge clk); check("wr_rvalid1", 32'(m1_rvalid_o), 32'd1);
        step(); m0_set(1, 15'h0020, 0, 4'hF, '0);
        step(); m0_set(0, '0, 0, 4'hF, '0);
        @(negedge clk);
        check("wr_rb_rvalid0", 32'(m0_rvalid_o), 32'd1);
        check("wr_rb_rdata0", m0_rdata_o, 32'hFFFF5678);

        // Streaming: 8 back-to-back m1 grants (priority currently favours m1)
        for (int i = 0; i < 9; i++) begin
            step();
            m1_set(i < 8, 15'(i * 4 + 64), 0, 4'hF, '0);
            @(negedge clk);
            if (i < 8) check("stream_gnt1", 32'(m1_gnt_o), 32'd1);
            if (i > 0) check("stream_rvalid1", 32'(m1_rvalid_o), 32'd1);
        end
        // Priority untouched by streaming: m1 still wins contention
        step(); m0_set(1, 15'h0004, 0, 4'hF, '0); m1_set(1, 15'h0008, 0, 4'hF, '0);
        @(negedge clk); check("stream_prio_gnt1", 32'(m1_gnt_o), 32'd1);
        step(); m1_set(0, '0, 0, 4'hF, '0);
        step(); m0_set(0, '0, 0, 4'hF, '0);
        // One contended cycle so m1 holds priority before the reset test
        m0_set(1, 15'h000C, 0, 4'hF, '0); m1_set(1, 15'h0030, 0, 4'hF, '0);
        @(negedge clk); check("pre_rst_gnt0", 32'(m0_gnt_o), 32'd1);
        step(); m0_set(0, '0, 0, 4'hF, '0);
        step(); m1_set(0, '0, 0, 4'hF, '0);

        // Reset one cycle after a grant
        m0_set(1, 15'h0010, 0, 4'hF, '0);
        @(negedge clk); check("rst_gnt0", 32'(m0_gnt_o), 32'd1);
        step(); rst_i = 1'b1; m1_set(1, 15'h0014, 0, 4'hF, '0);
        @(negedge clk);
        check("rst_rvalid0", 32'(m0_rvalid_o), 32'd0);
        check("rst_gnts", 32'({m0_gnt_o, m1_gnt_o}), 32'd0);
        check("rst_ram_en", 32'(ram_en_o), 32'd0);
        step(); rst_i = 1'b0;
        @(negedge clk); check("post_rst_prio_gnt0", 32'(m0_gnt_o), 32'd1);
        step(); m0_set(0, '0, 0, 4'hF, '0);
        step(); m1_set(0, '0, 0, 4'hF, '0);

        // Random traffic, requests held until granted
        busy0 = 0; busy1 = 0;
        for (int c = 0; c < 400; c++) begin
            step();
            if (!busy0 && $urandom_range(0, 2) != 0) begin
                busy0 = 1; idx = 6'($urandom_range(0, 63));
                m0_set(1, {7'd0, idx, 2'b00}, 1'($urandom_range(0, 1)),
                       4'($urandom_range(1, 15)), $urandom);
            end
            if (!busy1 && $urandom_range(0, 2) != 0) begin
                busy1 = 1; idx = 6'($urandom_range(0, 63));
                m1_set(1, {7'd0, idx, 2'b00}, 1'($urandom_range(0, 1)),
                       4'($urandom_range(1, 15)), $urandom);
            end
            m0_req_i = busy0;
            m1_req_i = busy1;
            @(negedge clk);
            if (m0_gnt_o) busy0 = 0;
            if (m1_gnt_o) busy1 = 0;
        end
        step(); m0_set(0, '0, 0, 4'hF, '0); m1_set(0, '0, 0, 4'hF, '0);
        step(); step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
